// File: rtl/fifo_cdc_pkg.sv
// Async FIFO CDC constants and Gray/binary helpers; combinational, no backpressure.
// Helpers work on a 32-bit zero-extended word, so callers cast to their pointer width.
package fifo_cdc_pkg;

  localparam int PTR_W       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int FN_W        = 32;

  function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended upper bits contribute nothing to the running XOR.
  function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
    logic [FN_W-1:0] b;
    b = '0;
    b[FN_W-1] = g[FN_W-1];
    for (int i = FN_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/cdc_sync_chain.sv
// Multi-flop synchronizer, STAGES cycles latency, sync active-low clear; no backpressure.
// Stage 0 samples din; dout is the last stage.
module cdc_sync_chain #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  (* ASYNC_REG = "TRUE", dont_retime = "true", shreg_extract = "no" *)
  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];

  always_comb begin
    sync_d[0] = din;
    for (int k = 1; k < STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '{default: '0};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// Pointer CDC: bin->Gray (0 cycles), SYNC_STAGES-flop sync, Gray->bin (0 cycles after sync).
// No handshake or backpressure; the source must step bin_in by at most one per cycle.
module gray_ptr_sync
  import fifo_cdc_pkg::*;
#(
  parameter int WIDTH       = fifo_cdc_pkg::PTR_W,
  parameter int SYNC_STAGES = fifo_cdc_pkg::SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bin_in,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] gray_sync,
  output logic [WIDTH-1:0] bin_sync
);

  assign gray_out = WIDTH'(bin2gray(FN_W'(bin_in)));

  cdc_sync_chain #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (gray_out),
    .dout (gray_sync)
  );

  assign bin_sync = WIDTH'(gray2bin(FN_W'(gray_sync)));

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Directed bench for gray_ptr_sync: default 4/2 instance plus a 5/3 variant.
// Expected sync outputs travel through per-instance scoreboard queues.
module tb_gray_ptr_sync;

  typedef struct {
    logic [31:0] g;
    logic [31:0] b;
  } ent_t;

  logic       clk;
  logic       rst;
  logic [3:0] bin4;
  logic [3:0] gout4, gsync4, bsync4;
  logic [4:0] bin5;
  logic [4:0] gout5, gsync5, bsync5;

  ent_t q4[$];
  ent_t q5[$];
  ent_t e;
  int   n_pass;
  int   n_total;
  logic [3:0] prev_g;

  gray_ptr_sync #(.WIDTH(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst(rst), .bin_in(bin4),
    .gray_out(gout4), .gray_sync(gsync4), .bin_sync(bsync4)
  );

  gray_ptr_sync #(.WIDTH(5), .SYNC_STAGES(3)) dut5 (
    .clk(clk), .rst(rst), .bin_in(bin5),
    .gray_out(gout5), .gray_sync(gsync5), .bin_sync(bsync5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] g_of(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge: update both scoreboards from the inputs sampled at the edge,
  // then compare the registered outputs 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (!rst) begin
      q4 = {};
      q5 = {};
      repeat (2) q4.push_back('{g: 32'd0, b: 32'd0});
      repeat (3) q5.push_back('{g: 32'd0, b: 32'd0});
    end else begin
      void'(q4.pop_front());
      void'(q5.pop_front());
      q4.push_back('{g: g_of(32'(bin4)), b: 32'(bin4)});
      q5.push_back('{g: g_of(32'(bin5)), b: 32'(bin5)});
    end
    #1;
    e = q4[0];
    check("gray_sync4", 32'(gsync4), e.g);
    check("bin_sync4",  32'(bsync4), e.b);
    e = q5[0];
    check("gray_sync5", 32'(gsync5), e.g);
    check("bin_sync5",  32'(bsync5), e.b);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst  = 1'b0;
    bin4 = 4'hA;
    bin5 = 5'd0;
    #1;
    check("reset_gray_out", 32'(gout4), 32'hF);
    repeat (3) begin
      step();
      check("reset_gsync_zero", 32'(gsync4), 32'd0);
      check("reset_bsync_zero", 32'(bsync4), 32'd0);
      check("reset_gray_out_hold", 32'(gout4), 32'hF);
    end

    // Latency: exactly two edges for the default instance.
    rst  = 1'b1;
    bin4 = 4'b0101;
    #1;
    check("lat_gray_out", 32'(gout4), 32'b0111);
    step();
    check("lat_gsync_edge1", 32'(gsync4), 32'd0);
    step();
    check("lat_gsync_edge2", 32'(gsync4), 32'b0111);
    check("lat_bsync_edge2", 32'(bsync4), 32'b0101);

    // Sweep 0..15..0 with a one-edge reset pulse at 9.
    bin4 = 4'd0;
    #1;
    prev_g = gout4;
    step();
    for (int v = 1; v <= 16; v++) begin
      bin4 = 4'(v);
      if (v == 9) rst = 1'b0;
      #1;
      check("sweep_gray_out", 32'(gout4), g_of(32'(bin4)));
      check("sweep_one_bit", 32'($countones(gout4 ^ prev_g)), 32'd1);
      prev_g = gout4;
      step();
      if (v == 9) begin
        check("midrst_gsync", 32'(gsync4), 32'd0);
        check("midrst_bsync", 32'(bsync4), 32'd0);
        rst = 1'b1;
      end
    end
    check("wrap_gray_zero", 32'(gout4), 32'd0);

    // Exhaustive decode, each value held for three edges.
    for (int v = 0; v < 16; v++) begin
      bin4 = 4'(v);
      repeat (3) step();
      check("exh_bsync", 32'(bsync4), 32'(v));
      check("exh_gsync", 32'(gsync4), g_of(32'(v)));
    end

    // WIDTH=5 / SYNC_STAGES=3 variant.
    bin5 = 5'b10110;
    #1;
    check("v5_gray_out", 32'(gout5), 32'b11101);
    step();
    check("v5_bsync_edge1", 32'(bsync5), 32'd0);
    step();
    check("v5_bsync_edge2", 32'(bsync5), 32'd0);
    step();
    check("v5_bsync_edge3", 32'(bsync5), 32'b10110);
    check("v5_gsync_edge3", 32'(gsync5), 32'b11101);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gray_ptr_sync.md
Name: gray_ptr_sync

Overview:
Pointer clock-domain-crossing block for the async FIFO. It converts a binary pointer from the source domain to Gray code and passes that Gray word through a multi-flop synchronizer clocked by the destination clock. It then converts the synchronized Gray word back to binary. One instance sits on each pointer path: the write pointer into the read domain, and the read pointer into the write domain.

Parameters:
- WIDTH, 4, pointer width in bits (legal: >=1).
- SYNC_STAGES, 2, number of flops in the synchronizer chain (legal: >=2).

Ports:
- clk  input  1  destination-domain clock; all flops are rising-edge.
- rst  input  1  reset; synchronous, active-low (0 = reset).
- bin_in  input  WIDTH  binary pointer from the source domain; the source drives it from a register.
- gray_out  output  WIDTH  combinational Gray encoding of bin_in; this is the word crossing the domain.
- gray_sync  output  WIDTH  last synchronizer stage (registered Gray).
- bin_sync  output  WIDTH  binary decode of gray_sync (combinational from the register).

Behaviour:
- Binary to Gray: gray_out = bin_in XOR (bin_in >> 1).
  - gray_out[WIDTH-1] = bin_in[WIDTH-1].
  - Purely combinational, zero latency.
- Gray to binary:
  - bin_sync[WIDTH-1] = gray_sync[WIDTH-1].
  - bin_sync[i] = bin_sync[i+1] XOR gray_sync[i], for i = WIDTH-2 down to 0.
  - Purely combinational from gray_sync.
- Synchronizer:
  - A chain of SYNC_STAGES WIDTH-bit registers on clk.
  - Stage 0 samples gray_out; stage k samples stage k-1.
  - gray_sync = the last stage.
- Latency: a stable bin_in value appears on gray_sync and bin_sync exactly SYNC_STAGES rising edges after it is first sampled. With the default, that is the 2nd edge.
- Reset:
  - On a rising edge with rst==0, every synchronizer stage loads 0, so gray_sync=0 and bin_sync=0 from that edge on.
  - rst takes priority over sampling.
  - gray_out is unaffected by reset; it always reflects bin_in.
- Reset mid-operation: the chain clears on the same edge. After rst returns to 1, the current bin_in reappears after SYNC_STAGES edges, with no partial values.
- Wrap-around:
  - A pointer step from 2^WIDTH-1 to 0 changes exactly one Gray bit (for WIDTH=4: 1000 -> 0000).
  - bin_sync follows modulo 2^WIDTH.
- Only single-step increments of bin_in per source cycle are guaranteed CDC-safe. This is a usage rule, not a checked condition.
- No other state exists: no enables, no handshakes.
- Synthesis attribute: mark the synchronizer flops ASYNC_REG / do-not-retime.

Decomposition:
- Shared package fifo_cdc_pkg holds:
  - default constants PTR_W=4 and SYNC_STAGES=2;
  - functions bin2gray(WIDTH) and gray2bin(WIDTH), reused by the FIFO full/empty logic.
- One natural sub-module: cdc_sync_chain (parameters WIDTH and STAGES; ports clk, rst, din, dout).
  - gray_ptr_sync instantiates it between the two package functions.

Test Plan:
- Reset: hold rst=0 for 3 edges with bin_in=4'hA. Required: gray_sync=0, bin_sync=0 throughout; gray_out=4'hF immediately.
- Latency: release rst, set bin_in=4'b0101. Required: gray_out=4'b0111 immediately; gray_sync=4'b0111 and bin_sync=4'b0101 after exactly 2 edges, with gray_sync still 0 after 1 edge.
- Sweep with wrap: increment bin_in 0..15..0, one step per clock. Required:
  - gray_out changes exactly one bit per step, including 15->0 (4'b1000 -> 4'b0000);
  - bin_sync equals bin_in delayed by 2 edges for every value.
- Mid-operation reset: during the sweep at bin_in=9, pulse rst=0 for 1 edge. Required:
  - gray_sync and bin_sync go to 0 on that edge;
  - after rst=1 they resume tracking bin_in with 2-edge latency.
- Exhaustive decode: for every 4-bit bin_in held 3 edges, check bin_sync==bin_in and gray_sync==bin_in^(bin_in>>1).
- Parameter variant WIDTH=5, SYNC_STAGES=3: bin_in=5'b10110 gives gray_out=5'b11101, with bin_sync=5'b10110 after exactly 3 edges.
